// File: rtl/future_round_if.sv
// Host/datapath handshake and control bundle for the FUTURE round controller.
// master: the controller; slave: the host plus round datapath it steers.
interface future_round_if #(
  parameter int unsigned RW = 4
);
  logic          in_valid;
  logic          in_ready;
  logic          out_valid;
  logic          out_ready;
  logic [0:63]   mux_sel;
  logic          state_en;
  logic [RW-1:0] round_idx;
  logic          key_sel;
  logic          last_round;
  logic          busy;

  modport master (
    input  in_valid,
    input  out_ready,
    output in_ready,
    output out_valid,
    output mux_sel,
    output state_en,
    output round_idx,
    output key_sel,
    output last_round,
    output busy
  );

  modport slave (
    output in_valid,
    output out_ready,
    input  in_ready,
    input  out_valid,
    input  mux_sel,
    input  state_en,
    input  round_idx,
    input  key_sel,
    input  last_round,
    input  busy
  );
endinterface

// File: rtl/future_round_ctrl.sv
// Iteration controller for the FUTURE 64-bit cipher: one load then NROUNDS rounds.
// Optional FUTURE_CTRL_ABORT_EN adds an abort input that cancels a block in LOAD/ROUND.
module future_round_ctrl #(
  parameter int unsigned NROUNDS = 10,
  parameter int unsigned RW      = 4
) (
  input  logic clk,
  input  logic rst,
`ifdef FUTURE_CTRL_ABORT_EN
  input  logic abort,
`endif
  future_round_if.master bus
);

  localparam int unsigned MUX_W = 64;
  localparam logic [RW-1:0] LAST_IDX = RW'(NROUNDS);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_LOAD  = 2'd1,
    S_ROUND = 2'd2,
    S_DONE  = 2'd3
  } state_e;

  state_e        state_q;
  state_e        state_d;
  logic [RW-1:0] cnt_q;
  logic [RW-1:0] cnt_d;
  logic          abort_c;

  logic             in_ready_c;
  logic             out_valid_c;
  logic [MUX_W-1:0] mux_sel_c;
  logic             state_en_c;
  logic             busy_c;

`ifdef FUTURE_CTRL_ABORT_EN
  assign abort_c = abort;
`else
  assign abort_c = 1'b0;
`endif

  // State and round counter register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state and output decode; only in_ready (DONE) and state_en (abort) see inputs
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    in_ready_c  = 1'b0;
    out_valid_c = 1'b0;
    mux_sel_c   = '0;
    state_en_c  = 1'b0;
    busy_c      = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        in_ready_c = 1'b1;
        cnt_d      = '0;
        if (bus.in_valid) begin
          state_d = S_LOAD;
        end
      end

      S_LOAD: begin
        mux_sel_c  = '1;
        busy_c     = 1'b1;
        state_en_c = ~abort_c;
        if (abort_c) begin
          state_d = S_IDLE;
          cnt_d   = '0;
        end else begin
          state_d = S_ROUND;
          cnt_d   = RW'(1);
        end
      end

      S_ROUND: begin
        busy_c     = 1'b1;
        state_en_c = ~abort_c;
        if (abort_c) begin
          state_d = S_IDLE;
          cnt_d   = '0;
        end else if (cnt_q == LAST_IDX) begin
          state_d = S_DONE;
        end else begin
          cnt_d = cnt_q + RW'(1);
        end
      end

      S_DONE: begin
        out_valid_c = 1'b1;
        in_ready_c  = bus.out_ready;
        if (bus.out_ready) begin
          // Back-to-back: a waiting block is loaded without an IDLE bubble
          state_d = bus.in_valid ? S_LOAD : S_IDLE;
          cnt_d   = '0;
        end
      end

      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  assign bus.in_ready   = in_ready_c;
  assign bus.out_valid  = out_valid_c;
  assign bus.mux_sel    = mux_sel_c;
  assign bus.state_en   = state_en_c;
  assign bus.busy       = busy_c;
  assign bus.round_idx  = cnt_q;
  assign bus.key_sel    = cnt_q[0];
  assign bus.last_round = (cnt_q == LAST_IDX);

endmodule

// File: tb/tb_future_round_ctrl.sv
// Bench for future_round_ctrl: block-position model plus a stub datapath (b = c + 1).
module tb_future_round_ctrl;

  localparam int unsigned N  = 10;
  localparam int unsigned RW = 4;
  localparam logic [63:0] A_IN  = 64'h4384_7844_1712_0101;
  localparam logic [63:0] A_FIN = 64'h4384_7844_1712_010B;

  logic clk = 1'b0;
  logic rst;
  logic abort;
  logic in_valid;
  logic out_ready;

  int n_vec = 0;
  int n_err = 0;
  int cycle = 0;

  future_round_if #(.RW(RW)) bus ();

  assign bus.in_valid  = in_valid;
  assign bus.out_ready = out_ready;

  future_round_ctrl #(.NROUNDS(N), .RW(RW)) dut (
    .clk   (clk),
    .rst   (rst),
`ifdef FUTURE_CTRL_ABORT_EN
    .abort (abort),
`endif
    .bus   (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cycle <= cycle + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s @cycle %0d: got %0h expected %0h", name, cycle, act, exp);
    end
  endtask

  // Stub datapath: mux feeds a (load) or state+1 (round) into the state register
  logic [63:0] dp;
  always @(posedge clk) begin
    logic [63:0] m;
    m = 64'(bus.mux_sel);
    if (bus.state_en) dp <= (A_IN & m) | ((dp + 64'd1) & ~m);
  end

  // Model: pos = -1 idle, 0 load, 1..N round number, N+1 result waiting
  int          pos   = -1;
  logic        armed = 1'b0;
  logic [63:0] md;
  logic        ab;

`ifdef FUTURE_CTRL_ABORT_EN
  assign ab = abort;
`else
  assign ab = 1'b0;
`endif

  always @(posedge clk) begin
    if (rst) begin
      pos   <= -1;
      armed <= 1'b1;
    end else if (pos == -1) begin
      if (in_valid) pos <= 0;
    end else if (pos <= int'(N)) begin
      if (ab) pos <= -1;
      else begin
        md  <= (pos == 0) ? A_IN : md + 64'd1;
        pos <= pos + 1;
      end
    end else if (out_ready) begin
      pos <= in_valid ? 0 : -1;
    end
  end

  always @(negedge clk) begin
    if (armed) begin
      int eri;
      eri = (pos <= 0) ? 0 : ((pos <= int'(N)) ? pos : int'(N));
      chk("in_ready", 64'(bus.in_ready),
          (pos == -1) ? 64'd1 : ((pos == int'(N) + 1) ? 64'(out_ready) : 64'd0));
      chk("out_valid", 64'(bus.out_valid), 64'(pos == int'(N) + 1));
      chk("mux_sel", 64'(bus.mux_sel), (pos == 0) ? '1 : 64'd0);
      chk("state_en", 64'(bus.state_en), 64'(pos >= 0 && pos <= int'(N) && !ab));
      chk("round_idx", 64'(bus.round_idx), 64'(eri));
      chk("key_sel", 64'(bus.key_sel), 64'(eri % 2));
      chk("last_round", 64'(bus.last_round), 64'(eri == int'(N)));
      chk("busy", 64'(bus.busy), 64'(pos >= 0 && pos <= int'(N)));
      if (pos == int'(N) + 1) chk("state_reg", dp, md);
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    int n = 0;
    out_ready = 1'b1;
    in_valid  = 1'b0;
    while (!(bus.in_ready && !bus.out_valid && !bus.busy) && n < 40) begin
      cyc();
      n++;
    end
    chk("drain_bound", 64'(n < 40), 64'd1);
    out_ready = 1'b0;
  endtask

  task automatic wait_round(input int k);
    int n = 0;
    while (!(bus.busy && int'(bus.round_idx) == k) && n < 30) begin
      cyc();
      n++;
    end
    chk("wait_round", 64'(bus.busy && int'(bus.round_idx) == k), 64'd1);
  endtask

  initial begin
    int lat, ones, lr, r, ov, np, idle_cnt;
    int t[3];
    logic [63:0] snap;

    // Reset held two cycles with in_valid high
    rst = 1'b1; in_valid = 1'b1; out_ready = 1'b0; abort = 1'b0;
    repeat (2) cyc();
    chk("rst_in_ready", 64'(bus.in_ready), 64'd1);
    chk("rst_out_valid", 64'(bus.out_valid), 64'd0);
    chk("rst_busy", 64'(bus.busy), 64'd0);
    chk("rst_round_idx", 64'(bus.round_idx), 64'd0);
    rst = 1'b0;
    cyc();
    chk("first_load_busy", 64'(bus.busy), 64'd1);
    chk("first_load_mux", 64'(bus.mux_sel), '1);
    drain();

    // Single block: latency, load pulse, round sequence, final data
    in_valid = 1'b1;
    cyc();
    in_valid = 1'b0;
    lat = 0; ones = 0; lr = 0; r = 1;
    while (!bus.out_valid && lat < 50) begin
      if (64'(bus.mux_sel) == '1) ones++;
      if (bus.busy && bus.last_round) lr++;
      if (bus.state_en && 64'(bus.mux_sel) == 64'd0) begin
        chk("round_step", 64'(bus.round_idx), 64'(r));
        r++;
      end
      cyc();
      lat++;
    end
    chk("latency_edges", 64'(lat), 64'(N + 1));
    chk("load_cycles", 64'(ones), 64'd1);
    chk("last_round_cycles", 64'(lr), 64'd1);
    chk("rounds_seen", 64'(r - 1), 64'(N));
    chk("ciphertext", dp, A_FIN);

    // Backpressure in DONE with a new block already offered
    out_ready = 1'b0; in_valid = 1'b1;
    snap = dp;
    repeat (5) begin
      cyc();
      chk("bp_out_valid", 64'(bus.out_valid), 64'd1);
      chk("bp_state_en", 64'(bus.state_en), 64'd0);
      chk("bp_in_ready", 64'(bus.in_ready), 64'd0);
      chk("bp_reg_stable", dp, snap);
    end
    in_valid = 1'b0; out_ready = 1'b1;
    cyc();
    chk("bp_release_idle", 64'(bus.in_ready && !bus.out_valid && !bus.busy), 64'd1);
    out_ready = 1'b0;

    // Back-to-back blocks
    in_valid = 1'b1; out_ready = 1'b1;
    np = 0; idle_cnt = 0;
    for (int i = 0; i < 60 && np < 3; i++) begin
      cyc();
      if (bus.out_valid) begin
        t[np] = cycle;
        np++;
      end else if (np > 0 && bus.in_ready) begin
        idle_cnt++;
      end
    end
    chk("b2b_pulses", 64'(np), 64'd3);
    chk("b2b_period_1", 64'(t[1] - t[0]), 64'(N + 2));
    chk("b2b_period_2", 64'(t[2] - t[1]), 64'(N + 2));
    chk("b2b_no_idle", 64'(idle_cnt), 64'd0);
    in_valid = 1'b0;
    cyc();
    out_ready = 1'b0;

    // Reset at round 5 aborts the block
    in_valid = 1'b1;
    cyc();
    in_valid = 1'b0;
    wait_round(5);
    rst = 1'b1;
    cyc();
    chk("midrst_round_idx", 64'(bus.round_idx), 64'd0);
    chk("midrst_busy", 64'(bus.busy), 64'd0);
    chk("midrst_in_ready", 64'(bus.in_ready), 64'd1);
    rst = 1'b0;
    out_ready = 1'b1;
    ov = 0;
    repeat (20) begin
      cyc();
      if (bus.out_valid) ov++;
    end
    chk("midrst_no_out", 64'(ov), 64'd0);
    out_ready = 1'b0;

`ifdef FUTURE_CTRL_ABORT_EN
    // Abort in round 3 cancels; abort while DONE is ignored
    in_valid = 1'b1;
    cyc();
    in_valid = 1'b0;
    wait_round(3);
    abort = 1'b1;
    #1;
    chk("abort_state_en", 64'(bus.state_en), 64'd0);
    cyc();
    abort = 1'b0;
    chk("abort_idle", 64'(bus.in_ready && !bus.busy), 64'd1);
    in_valid = 1'b1;
    cyc();
    in_valid = 1'b0;
    wait_round(int'(N));
    cyc();
    abort = 1'b1;
    repeat (3) begin
      cyc();
      chk("abort_done_ignored", 64'(bus.out_valid), 64'd1);
    end
    abort = 1'b0;
    drain();
`endif

    cyc();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
